// File: rtl/regfile_write_queue_if.sv
// ============================================================================
// regfile_write_queue_if : write-request channel (valid/ready) into the queue
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_write_queue_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 1
);
  logic              WR_VALID;
  logic              WR_READY;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [WIDTH-1:0]  WR_DATA;

  modport master (
    output WR_VALID,
    output WR_ADDR,
    output WR_DATA,
    input  WR_READY
  );

  modport slave (
    input  WR_VALID,
    input  WR_ADDR,
    input  WR_DATA,
    output WR_READY
  );
endinterface

`default_nettype wire

// File: rtl/regfile_write_queue.sv
// ============================================================================
// regfile_write_queue : in-order write-back FIFO retiring one-hot CE + data
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_queue #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 2,
  parameter int ADDR_W = 1,
  parameter int DEPTH  = 4
) (
  input  wire logic                       CLK,
  input  wire logic                       RESET,
  regfile_write_queue_if.slave            wr,
  input  wire logic                       DRAIN,
  output logic [NREGS-1:0]                CE,
  output logic [WIDTH-1:0]                WDATA,
  input  wire logic [ADDR_W-1:0]          RD_ADDR,
  output logic                            RD_HIT,
  output logic [WIDTH-1:0]                RD_DATA,
  output logic [$clog2(DEPTH+1)-1:0]      COUNT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] entry_addr_q [DEPTH];
  logic [ADDR_W-1:0] entry_addr_d [DEPTH];
  logic [WIDTH-1:0]  entry_data_q [DEPTH];
  logic [WIDTH-1:0]  entry_data_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              wr_ready;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  scan_idx;

  assign wr_ready    = (count_q != CNT_W'(DEPTH));
  assign wr.WR_READY = wr_ready;
  assign push        = wr.WR_VALID && wr_ready;
  assign pop         = DRAIN && (count_q != '0);
  assign COUNT       = count_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    valid_d      = valid_q;
    entry_addr_d = entry_addr_q;
    entry_data_d = entry_data_q;

    // Push and pop never target the same slot: pop needs COUNT>0, push needs COUNT<DEPTH.
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      valid_d[wr_ptr_q]      = 1'b1;
      entry_addr_d[wr_ptr_q] = wr.WR_ADDR;
      entry_data_d[wr_ptr_q] = wr.WR_DATA;
      wr_ptr_d               = wr_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge CLK) begin
    entry_addr_q <= entry_addr_d;
    entry_data_q <= entry_data_d;
  end

  // Out-of-range head addresses match no CE bit, so the pop happens with CE=0.
  always_comb begin
    CE    = '0;
    WDATA = '0;
    for (int r = 0; r < NREGS; r++) begin
      CE[r] = pop && (entry_addr_q[rd_ptr_q] == ADDR_W'(r));
    end
    if (pop) begin
      WDATA = entry_data_q[rd_ptr_q];
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    RD_HIT   = 1'b0;
    RD_DATA  = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr_q + PTR_W'(i);
      if (valid_q[scan_idx] && (entry_addr_q[scan_idx] == RD_ADDR)) begin
        RD_HIT  = 1'b1;
        RD_DATA = entry_data_q[scan_idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_queue.sv
// ============================================================================
// tb_regfile_write_queue : directed stimulus with a retire-side scoreboard
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_queue;

  logic        clk;
  logic        rst;
  logic        drain_a, drain_b;
  logic        rd_addr_a;
  logic [1:0]  rd_addr_b;
  logic [1:0]  ce_a;
  logic [2:0]  ce_b;
  logic [31:0] wd_a, wd_b;
  logic        hit_a, hit_b;
  logic [31:0] rdd_a, rdd_b;
  logic [2:0]  cnt_a, cnt_b;

  logic [31:0] reg0, reg1;

  int tests = 0;
  int fails = 0;

  logic [33:0] exp_a_q [$];
  logic [34:0] exp_b_q [$];
  logic [33:0] ea;
  logic [34:0] eb;

  regfile_write_queue_if #(.WIDTH(32), .ADDR_W(1)) wif_a ();
  regfile_write_queue_if #(.WIDTH(32), .ADDR_W(2)) wif_b ();

  regfile_write_queue #(.WIDTH(32), .NREGS(2), .ADDR_W(1), .DEPTH(4)) dut_a (
    .CLK(clk), .RESET(rst), .wr(wif_a.slave), .DRAIN(drain_a),
    .CE(ce_a), .WDATA(wd_a), .RD_ADDR(rd_addr_a), .RD_HIT(hit_a),
    .RD_DATA(rdd_a), .COUNT(cnt_a)
  );

  regfile_write_queue #(.WIDTH(32), .NREGS(3), .ADDR_W(2), .DEPTH(4)) dut_b (
    .CLK(clk), .RESET(rst), .wr(wif_b.slave), .DRAIN(drain_b),
    .CE(ce_b), .WDATA(wd_b), .RD_ADDR(rd_addr_b), .RD_HIT(hit_b),
    .RD_DATA(rdd_b), .COUNT(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream register pair: reset has priority over CE.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg0 <= 32'h0000_0000;
      reg1 <= 32'h0000_0018;
    end else begin
      if (ce_a[0]) reg0 <= wd_a;
      if (ce_a[1]) reg1 <= wd_a;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && drain_a && cnt_a != 3'd0) begin
      if (exp_a_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL retire_a: unexpected retire ce=%b wdata=%h", ce_a, wd_a);
      end else begin
        ea = exp_a_q.pop_front();
        check("retire_a_ce", 64'(ce_a), 64'(ea[33:32]));
        check("retire_a_wdata", 64'(wd_a), 64'(ea[31:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && drain_b && cnt_b != 3'd0) begin
      if (exp_b_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL retire_b: unexpected retire ce=%b wdata=%h", ce_b, wd_b);
      end else begin
        eb = exp_b_q.pop_front();
        check("retire_b_ce", 64'(ce_b), 64'(eb[34:32]));
        check("retire_b_wdata", 64'(wd_b), 64'(eb[31:0]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic a, input logic [31:0] d);
    wif_a.WR_VALID = 1'b1;
    wif_a.WR_ADDR  = a;
    wif_a.WR_DATA  = d;
    exp_a_q.push_back({(a ? 2'b10 : 2'b01), d});
    cyc();
    wif_a.WR_VALID = 1'b0;
  endtask

  task automatic push_b(input logic [1:0] a, input logic [31:0] d, input logic [2:0] ce);
    wif_b.WR_VALID = 1'b1;
    wif_b.WR_ADDR  = a;
    wif_b.WR_DATA  = d;
    exp_b_q.push_back({ce, d});
    cyc();
    wif_b.WR_VALID = 1'b0;
  endtask

  logic [31:0] vec_d [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
  logic        vec_a [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst = 1'b1;
    drain_a = 1'b0;
    drain_b = 1'b0;
    rd_addr_a = 1'b0;
    rd_addr_b = 2'd0;
    wif_a.WR_VALID = 1'b0;
    wif_a.WR_ADDR  = '0;
    wif_a.WR_DATA  = '0;
    wif_b.WR_VALID = 1'b0;
    wif_b.WR_ADDR  = '0;
    wif_b.WR_DATA  = '0;
    cyc();
    cyc();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      check("idle_ce", 64'(ce_a), 64'd0);
      check("idle_wdata", 64'(wd_a), 64'd0);
      check("idle_count", 64'(cnt_a), 64'd0);
      check("idle_ready", 64'(wif_a.WR_READY), 64'd1);
      check("idle_hit", 64'(hit_a), 64'd0);
      cyc();
    end

    // Single write, immediate drain
    drain_a = 1'b1;
    push_a(1'b1, 32'hDEAD_BEEF);
    check("single_count", 64'(cnt_a), 64'd1);
    check("single_ce", 64'(ce_a), 64'b10);
    check("single_wdata", 64'(wd_a), 64'hDEAD_BEEF);
    cyc();
    check("single_count_after", 64'(cnt_a), 64'd0);
    check("single_ce_after", 64'(ce_a), 64'd0);
    check("single_reg1", 64'(reg1), 64'hDEAD_BEEF);

    // Fill to full with retirement stalled
    drain_a = 1'b0;
    for (int i = 0; i < 4; i++) push_a(vec_a[i], vec_d[i]);
    check("full_count", 64'(cnt_a), 64'd4);
    check("full_ready", 64'(wif_a.WR_READY), 64'd0);
    rd_addr_a = 1'b0;
    #1;
    check("fwd_hit0", 64'(hit_a), 64'd1);
    check("fwd_data0", 64'(rdd_a), 64'd3);
    rd_addr_a = 1'b1;
    #1;
    check("fwd_data1", 64'(rdd_a), 64'd4);
    wif_a.WR_VALID = 1'b1;
    wif_a.WR_ADDR  = 1'b0;
    wif_a.WR_DATA  = 32'h99;
    cyc();
    check("full_holdoff_count", 64'(cnt_a), 64'd4);
    wif_a.WR_VALID = 1'b0;
    drain_a = 1'b1;
    rd_addr_a = 1'b0;
    #1;
    check("fwd_during_retire_hit", 64'(hit_a), 64'd1);
    check("fwd_during_retire_data", 64'(rdd_a), 64'd3);
    for (int i = 0; i < 4; i++) cyc();
    check("drained_count", 64'(cnt_a), 64'd0);
    check("drained_hit", 64'(hit_a), 64'd0);
    check("drained_rddata", 64'(rdd_a), 64'd0);

    // Simultaneous push and pop, pointers wrap
    drain_a = 1'b0;
    push_a(1'b0, 32'h10);
    push_a(1'b1, 32'h11);
    drain_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_a(1'((i & 1) != 0), 32'h20 + 32'(i));
      check("steady_count", 64'(cnt_a), 64'd2);
    end
    cyc();
    cyc();
    check("steady_drained", 64'(cnt_a), 64'd0);

    // Reset mid-drain discards pending entries
    drain_a = 1'b0;
    push_a(1'b1, 32'hA1);
    push_a(1'b0, 32'hA2);
    push_a(1'b1, 32'hA3);
    drain_a = 1'b1;
    cyc();
    rst = 1'b1;
    exp_a_q.delete();
    cyc();
    rst = 1'b0;
    check("rst_count", 64'(cnt_a), 64'd0);
    check("rst_ce", 64'(ce_a), 64'd0);
    check("rst_reg1", 64'(reg1), 64'h18);
    check("rst_reg0", 64'(reg0), 64'd0);
    cyc();
    cyc();
    check("rst_ce_later", 64'(ce_a), 64'd0);
    check("rst_reg1_later", 64'(reg1), 64'h18);
    check("rst_reg0_later", 64'(reg0), 64'd0);
    drain_a = 1'b0;

    // Out-of-range address on the three-register instance
    push_b(2'd3, 32'h55, 3'b000);
    push_b(2'd2, 32'h66, 3'b100);
    drain_b = 1'b1;
    rd_addr_b = 2'd3;
    #1;
    check("oor_ce", 64'(ce_b), 64'd0);
    check("oor_count", 64'(cnt_b), 64'd2);
    check("oor_fwd_hit", 64'(hit_b), 64'd1);
    check("oor_fwd_data", 64'(rdd_b), 64'h55);
    cyc();
    check("b_ce2", 64'(ce_b), 64'b100);
    check("b_wdata2", 64'(wd_b), 64'h66);
    check("b_count1", 64'(cnt_b), 64'd1);
    cyc();
    check("b_count0", 64'(cnt_b), 64'd0);
    check("b_ce_idle", 64'(ce_b), 64'd0);
    drain_b = 1'b0;
    cyc();

    check("scoreboard_a_empty", 64'(exp_a_q.size()), 64'd0);
    check("scoreboard_b_empty", 64'(exp_b_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
